usb_tx_ctrl: RTL and testbench

FPGA-side transmit controller for the FTDI FT60x bus in 245 synchronous FIFO mode. Accepts 32-bit words from upstream logic over a valid/ready stream and buffers them internally. Once a full packet is buffered and the FTDI reports space (TXE_N low), it writes the packet to the chip as one unbroken write burst. Sits directly upstream of the FTDI device (or its bench imitation) and owns the write cycle on ioDATA/ioBE.

---
 rtl/usb_pkg.sv | 17 +
 rtl/usb_tx_fifo.sv | 53 +++++
 rtl/usb_tx_ctrl.sv | 133 +++++++++++++
 tb/tb_usb_tx_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the FT60x 245-mode transmit path.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_TXE = 2'd1,
    BURST    = 2'd2,
    GAP      = 2'd3
  } tx_state_t;

  localparam logic [3:0] FT_BE_ALL   = 4'hF;
  localparam logic [1:0] FT_MODE_245 = 2'b00;

  localparam int DEFAULT_PKT_WORDS  = 1024;
  localparam int DEFAULT_FIFO_DEPTH = 2048;

endpackage

// File: rtl/usb_tx_fifo.sv
// Synchronous show-ahead FIFO: rd_data_o always shows the oldest word; rd_en_i consumes it.
module usb_tx_fifo #(
  parameter  int DEPTH = 2048,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_fire = wr_en_i & ~full_o;
  assign rd_fire = rd_en_i & ~empty_o;

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/usb_tx_ctrl.sv
// FT60x 245 synchronous FIFO write controller: buffers upstream words, writes whole packets as unbroken bursts.
// Define USB_TX_TEST_PATTERN_EN to replace the buffered path with an internal incrementing counter source.
module usb_tx_ctrl
  import usb_pkg::*;
#(
  parameter int PKT_WORDS  = DEFAULT_PKT_WORDS,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [31:0] iDATA,
  input  logic        iVALID,
  output logic        oREADY,
  inout  wire  [31:0] ioDATA,
  inout  wire  [3:0]  ioBE,
  input  logic        iTXE_N,
  output logic        oWR_N,
  output logic        oOE_N,
  output logic        oRD_N,
  output logic [1:0]  oGPIO,
  output logic        oBUSY,
  output logic        oERR
);

  localparam int            CW        = $clog2(PKT_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(PKT_WORDS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          txe_n_q;
  logic          wr_n_q;
  logic [31:0]   data_q;
  logic          err_q;
  logic          pkt_avail;
  logic          pop;
  logic [31:0]   head_data;

`ifdef USB_TX_TEST_PATTERN_EN
  logic [31:0] pat_q;
  logic        unused_inputs;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)  pat_q <= '0;
    else if (pop) pat_q <= pat_q + 32'd1;
  end

  assign pkt_avail     = 1'b1;
  assign head_data     = pat_q;
  assign oREADY        = 1'b0;
  assign unused_inputs = ^{iDATA, iVALID};
`else
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic          ready_q;
  logic          fifo_full;
  logic          fifo_empty_unused;
  logic [FW-1:0] fifo_count;

  // Holds oREADY low through reset and for the edge that releases it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  assign oREADY    = ready_q & ~fifo_full;
  assign pkt_avail = (fifo_count >= FW'(PKT_WORDS));

  usb_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .wr_en_i   (iVALID & oREADY),
    .wr_data_i (iDATA),
    .rd_en_i   (pop),
    .rd_data_o (head_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty_unused),
    .count_o   (fifo_count)
  );
`endif

  // A word is popped as it is loaded onto the bus: once on burst entry, then every burst cycle but the last.
  assign pop = ((state_q == WAIT_TXE) && !txe_n_q) ||
               ((state_q == BURST) && (word_cnt_q != LAST_WORD));

  // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      IDLE:     if (pkt_avail) state_d = WAIT_TXE;
      WAIT_TXE: if (!txe_n_q) begin
                  state_d    = BURST;
                  word_cnt_d = '0;
                end
      BURST:    if (word_cnt_q == LAST_WORD) state_d = GAP;
                else                         word_cnt_d = word_cnt_q + 1'b1;
      GAP:      if (txe_n_q) state_d = pkt_avail ? WAIT_TXE : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      txe_n_q    <= 1'b1;
      wr_n_q     <= 1'b1;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      txe_n_q    <= iTXE_N;
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      wr_n_q     <= (state_d != BURST);
      if (pop) data_q <= head_data;
      // TXE_N may legitimately rise as the final word goes out; earlier than that is a protocol breach.
      if ((state_q == BURST) && txe_n_q && (word_cnt_q < LAST_WORD)) err_q <= 1'b1;
    end
  end

  assign ioDATA = wr_n_q ? {32{1'bz}} : data_q;
  assign ioBE   = wr_n_q ? {4{1'bz}}  : FT_BE_ALL;
  assign oWR_N  = wr_n_q;
  assign oOE_N  = 1'b1;
  assign oRD_N  = 1'b1;
  assign oGPIO  = FT_MODE_245;
  assign oBUSY  = (state_q == BURST) || (state_q == GAP);
  assign oERR   = err_q;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Bench for usb_tx_ctrl: table-driven fill/ready checks plus burst sequences scored against a word queue.
`timescale 1ns/1ps
module tb_usb_tx_ctrl;

  localparam int          PKT      = 1024;
  localparam int          DEPTH    = 2048;
  localparam int          GAP_CYC  = 10000;   // 100 us of TXE_N high at a 10 ns clock
  localparam int          NONE     = 1 << 30;
  localparam logic [31:0] PROBE_D  = 32'h3C3C_C3C3;
  localparam logic [3:0]  PROBE_BE = 4'h0;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        valid   = 1'b0;
  logic        txe_n   = 1'b1;
  logic        probe   = 1'b0;
  logic [31:0] data_in = '0;
  logic        ready, wr_n, oe_n, rd_n, busy, err;
  logic [1:0]  gpio;
  wire  [31:0] io_data;
  wire  [3:0]  io_be;

  // The bench drives the bus only while probing that the DUT has released it.
  assign io_data = probe ? PROBE_D  : 'z;
  assign io_be   = probe ? PROBE_BE : 'z;

  int          n_vec     = 0;
  int          n_err     = 0;
  logic [31:0] next_word = '0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  usb_tx_ctrl #(
    .PKT_WORDS  (PKT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .iDATA  (data_in),
    .iVALID (valid),
    .oREADY (ready),
    .ioDATA (io_data),
    .ioBE   (io_be),
    .iTXE_N (txe_n),
    .oWR_N  (wr_n),
    .oOE_N  (oe_n),
    .oRD_N  (rd_n),
    .oGPIO  (gpio),
    .oBUSY  (busy),
    .oERR   (err)
  );

  typedef struct {
    string name;
    logic  txe_n;
    int    n_push;
    bit    try_only;
    int    wait_cyc;
    logic  exp_ready;
    logic  exp_wr_n;
    logic  exp_busy;
    logic  exp_err;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input string name, input logic t, input int n, input bit try_only,
                              input int w, input logic r, input logic wn, input logic b, input logic e);
    vec_t v;
    v.name = name; v.txe_n = t; v.n_push = n; v.try_only = try_only; v.wait_cyc = w;
    v.exp_ready = r; v.exp_wr_n = wn; v.exp_busy = b; v.exp_err = e;
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers words until n have been accepted; the model queue takes a word only when oREADY was high.
  task automatic push_words(input int n);
    int done  = 0;
    int guard = 0;
    while (done < n && guard < 20000) begin
      @(negedge clk);
      valid   = 1'b1;
      data_in = next_word;
      if (ready) begin
        exp_q.push_back(next_word);
        next_word++;
        done++;
      end
      guard++;
    end
    @(negedge clk);
    valid = 1'b0;
    if (done != n) check32("push_timeout", done, n);
  endtask

  task automatic try_word();
    @(negedge clk);
    valid   = 1'b1;
    data_in = next_word;
    if (ready) begin
      exp_q.push_back(next_word);
      next_word++;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    bit saw_low = 1'b0;
    txe_n = v.txe_n;
    if (v.try_only) try_word();
    else            push_words(v.n_push);
    for (int c = 0; c < v.wait_cyc; c++) begin
      @(negedge clk);
      if (!wr_n) saw_low = 1'b1;
    end
    check1({v.name, "_ready"}, ready, v.exp_ready);
    check1({v.name, "_wr_n"}, ~saw_low, v.exp_wr_n);
    check1({v.name, "_busy"}, busy, v.exp_busy);
    check1({v.name, "_err"}, err, v.exp_err);
  endtask

  // FTDI imitation: samples each strobed word, optionally pulses TXE_N or asserts reset at a word index.
  task automatic collect_burst(input int pulse_at, input int rst_at, output int len);
    int          wait_c = 0;
    logic [31:0] exp;
    len = 0;
    while (wr_n && wait_c < 4000) begin
      @(negedge clk);
      wait_c++;
    end
    if (wr_n) begin
      check1("burst_start", wr_n, 1'b0);
      return;
    end
    check1("busy_in_burst", busy, 1'b1);
    while (!wr_n && len < PKT + 16) begin
      if (exp_q.size() == 0) begin
        check32("sb_depth", 32'(exp_q.size()), 32'd1);
        exp = '0;
      end else begin
        exp = exp_q.pop_front();
      end
      check32("burst_data", io_data, exp);
      check32("burst_be", 32'(io_be), 32'hF);
      if (len == pulse_at)          txe_n = 1'b1;
      else if (len == pulse_at + 1) txe_n = 1'b0;
      len++;
      if (len == rst_at + 1) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic ftdi_gap();
    bit saw_low = 1'b0;
    txe_n = 1'b1;
    repeat (GAP_CYC) begin
      @(negedge clk);
      if (!wr_n) saw_low = 1'b1;
    end
    check1("gap_no_write", saw_low, 1'b0);
    txe_n = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit saw_low;

    vecs[0] = mk("first_word",   1'b0, 1,    1'b0, 8,   1'b1, 1'b1, 1'b0, 1'b0);
    vecs[1] = mk("partial_1023", 1'b0, 1022, 1'b0, 300, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[2] = mk("fill_2047",    1'b1, 2047, 1'b0, 8,   1'b1, 1'b1, 1'b0, 1'b0);
    vecs[3] = mk("fill_2048",    1'b1, 1,    1'b0, 8,   1'b0, 1'b1, 1'b0, 1'b0);
    vecs[4] = mk("reject_2049",  1'b1, 0,    1'b1, 8,   1'b0, 1'b1, 1'b0, 1'b0);

    // Reset state, with the bus probed for release.
    probe = 1'b1;
    repeat (4) @(negedge clk);
    check1("rst_wr_n", wr_n, 1'b1);
    check1("rst_oe_n", oe_n, 1'b1);
    check1("rst_rd_n", rd_n, 1'b1);
    check32("rst_gpio", 32'(gpio), 32'd0);
    check1("rst_ready", ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_be_z", 32'(io_be), 32'(PROBE_BE));
    check32("rst_data_z", io_data, PROBE_D);
    probe = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check1("ready_after_rst", ready, 1'b1);

    // Partial packet stays put; the 1024th word releases a single burst of words 0..1023.
    for (int i = 0; i < 2; i++) apply_vec(vecs[i]);
    push_words(1);
    collect_burst(NONE, NONE, len);
    check32("single_len", len, PKT);
    probe = 1'b1;
    #1;
    check32("bus_released", 32'(io_be), 32'(PROBE_BE));
    probe = 1'b0;
    txe_n = 1'b1;
    repeat (8) @(negedge clk);
    check1("busy_after_gap", busy, 1'b0);
    check1("err_single", err, 1'b0);

    // Fill to full with TXE_N high; the extra word must be refused.
    for (int i = 2; i < 5; i++) apply_vec(vecs[i]);

    // Burst start latency: registered TXE_N, then one more cycle to the first strobe.
    txe_n = 1'b0;
    @(negedge clk);
    check1("start_lat_1", wr_n, 1'b1);
    @(negedge clk);
    check1("start_lat_2", wr_n, 1'b0);
    collect_burst(NONE, NONE, len);
    check32("b2b_a_len", len, PKT);
    ftdi_gap();
    check1("err_b2b_a", err, 1'b0);

    // Second burst with a TXE_N glitch at word 500 while upstream keeps pushing.
    fork
      collect_burst(500, NONE, len);
      push_words(PKT);
    join
    check32("b2b_b_len", len, PKT);
    check1("err_midburst", err, 1'b1);
    ftdi_gap();

    // Reset at word 300 releases the bus at once and empties the buffer.
    collect_burst(NONE, 300, len);
    check1("abort_wr_n", wr_n, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_err", err, 1'b0);
    check1("abort_ready", ready, 1'b0);
    probe = 1'b1;
    #1;
    check32("abort_be_z", 32'(io_be), 32'(PROBE_BE));
    check32("abort_data_z", io_data, PROBE_D);
    exp_q.delete();
    repeat (3) @(negedge clk);
    probe = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check1("abort_ready_rel", ready, 1'b1);
    saw_low = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (!wr_n) saw_low = 1'b1;
    end
    check1("abort_idle", saw_low, 1'b0);
    push_words(PKT);
    collect_burst(NONE, NONE, len);
    check32("post_rst_len", len, PKT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
